// File: rtl/cc_pll_lock_model_if.sv
// cc_pll_lock_model_if: control/status bundle for the PLL lock model.
//   PLL_EN              master->slave  enable; low forces IDLE
//   USR_LOCKED_STDY_RST master->slave  synchronous clear of the steady flag
//   USR_PLL_LOCKED      slave->master  high while in LOCKED
//   USR_PLL_LOCKED_STDY slave->master  sticky steady-lock flag
//   CLK_EN[NUM_OUT]     slave->master  per-channel 1/DIV pulse
//   CLK_DIV[NUM_OUT]    slave->master  per-channel square wave, period 2*DIV
//   REF_GOOD, LOCK_LOST present only when CC_PLL_LOSS_DETECT_EN is defined.
interface cc_pll_lock_model_if #(
  parameter int unsigned NUM_OUT = 2
);
  logic               PLL_EN;
  logic               USR_LOCKED_STDY_RST;
  logic               USR_PLL_LOCKED;
  logic               USR_PLL_LOCKED_STDY;
  logic [NUM_OUT-1:0] CLK_EN;
  logic [NUM_OUT-1:0] CLK_DIV;
`ifdef CC_PLL_LOSS_DETECT_EN
  logic               REF_GOOD;
  logic               LOCK_LOST;

  modport master (
    output PLL_EN, USR_LOCKED_STDY_RST, REF_GOOD,
    input  USR_PLL_LOCKED, USR_PLL_LOCKED_STDY, CLK_EN, CLK_DIV, LOCK_LOST
  );
  modport slave (
    input  PLL_EN, USR_LOCKED_STDY_RST, REF_GOOD,
    output USR_PLL_LOCKED, USR_PLL_LOCKED_STDY, CLK_EN, CLK_DIV, LOCK_LOST
  );
`else
  modport master (
    output PLL_EN, USR_LOCKED_STDY_RST,
    input  USR_PLL_LOCKED, USR_PLL_LOCKED_STDY, CLK_EN, CLK_DIV
  );
  modport slave (
    input  PLL_EN, USR_LOCKED_STDY_RST,
    output USR_PLL_LOCKED, USR_PLL_LOCKED_STDY, CLK_EN, CLK_DIV
  );
`endif
endinterface

// File: rtl/cc_pll_lock_model.sv
// cc_pll_lock_model: behavioural PLL lock sequencer with phase-aligned
// divided clock-enable channels.
//   CLK_REF   sole clock, rising edge
//   USR_RSTN  asynchronous active-low reset
//   bus       cc_pll_lock_model_if.slave (enable/steady-clear in,
//             lock/steady/CLK_EN/CLK_DIV out)
// Optional feature macro: CC_PLL_LOSS_DETECT_EN adds REF_GOOD/LOCK_LOST and
// drops LOCKED back to ACQUIRE after LOSS_CYCLES consecutive bad-reference edges.
module cc_pll_lock_model #(
  parameter int unsigned                 NUM_OUT     = 2,
  parameter int unsigned                 DIV_WIDTH   = 8,
  parameter logic [NUM_OUT*DIV_WIDTH-1:0] DIV_RATIO  = {8'd4, 8'd2},
  parameter int unsigned                 LOCK_CYCLES = 64,
  parameter int unsigned                 STDY_CYCLES = 16,
  parameter int unsigned                 LOSS_CYCLES = 4
) (
  input  logic               CLK_REF,
  input  logic               USR_RSTN,
  cc_pll_lock_model_if.slave bus
);

  localparam int unsigned ACQ_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned STDY_W = (STDY_CYCLES > 1) ? $clog2(STDY_CYCLES) : 1;
  localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(LOCK_CYCLES - 1);
  localparam logic [STDY_W-1:0] STDY_LAST = STDY_W'(STDY_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam bit CFG_OK = (NUM_OUT >= 1) && (NUM_OUT <= 4) && (DIV_WIDTH >= 1) &&
                          (LOCK_CYCLES >= 1) && (STDY_CYCLES >= 1) && (LOSS_CYCLES >= 1);

  // Elaboration-time parameter sanity check
  if (!CFG_OK) begin : g_cfg_err
    $error("cc_pll_lock_model: illegal parameter set");
  end

  logic [1:0]                         state_q, state_d;
  logic [ACQ_W-1:0]                   acq_q, acq_d;
  logic [STDY_W-1:0]                  stdy_q, stdy_d;
  logic                               stdy_flag_q, stdy_flag_d;
  logic                               stdy_hold_q, stdy_hold_d;
  logic [NUM_OUT-1:0][DIV_WIDTH-1:0]  chan_q, chan_d, div_last;
  logic [NUM_OUT-1:0]                 div_q, div_d, en_q, en_d;
`ifdef CC_PLL_LOSS_DETECT_EN
  localparam int unsigned LOSS_W = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYCLES - 1);
  logic [LOSS_W-1:0]                  loss_q, loss_d;
  logic                               lost_q, lost_d;
`endif

  // Terminal count per channel (divide ratio minus one)
  always_comb begin
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      div_last[i] = DIV_RATIO[i*DIV_WIDTH +: DIV_WIDTH] - DIV_WIDTH'(1);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    acq_d       = acq_q;
    stdy_d      = stdy_q;
    stdy_flag_d = stdy_flag_q;
    stdy_hold_d = 1'b0;
    chan_d      = chan_q;
    div_d       = div_q;
    en_d        = '0;
`ifdef CC_PLL_LOSS_DETECT_EN
    loss_d      = loss_q;
    lost_d      = lost_q;
`endif

    case (state_q)
      ST_IDLE: begin
        acq_d = '0;
        if (bus.PLL_EN) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (acq_q == ACQ_LAST) begin
          state_d = ST_LOCKED;
          acq_d   = '0;
        end else begin
          acq_d = acq_q + ACQ_W'(1);
        end
      end
      ST_LOCKED: begin
        // Clear edge zeroes the count; the following (release) edge is not
        // counted, so the flag stays low STDY_CYCLES+1 cycles after a clear.
        if (bus.USR_LOCKED_STDY_RST) begin
          stdy_flag_d = 1'b0;
          stdy_d      = '0;
          stdy_hold_d = 1'b1;
        end else if (!stdy_hold_q && !stdy_flag_q) begin
          if (stdy_q == STDY_LAST) stdy_flag_d = 1'b1;
          else                     stdy_d      = stdy_q + STDY_W'(1);
        end
        for (int i = 0; i < int'(NUM_OUT); i++) begin
          if (chan_q[i] == div_last[i]) begin
            chan_d[i] = '0;
            div_d[i]  = ~div_q[i];
          end else begin
            chan_d[i] = chan_q[i] + DIV_WIDTH'(1);
          end
        end
`ifdef CC_PLL_LOSS_DETECT_EN
        if (!bus.REF_GOOD) begin
          if (loss_q == LOSS_LAST) begin
            state_d = ST_ACQUIRE;
            loss_d  = '0;
            lost_d  = 1'b1;
          end else begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef CC_PLL_LOSS_DETECT_EN
    if (bus.REF_GOOD) loss_d = '0;
`endif

    if (!bus.PLL_EN) begin
      state_d = ST_IDLE;
      acq_d   = '0;
`ifdef CC_PLL_LOSS_DETECT_EN
      lost_d  = 1'b0;
`endif
    end

    // Lock-qualified state is cleared whenever the next state is not LOCKED,
    // which also guarantees phase-aligned channels on every LOCKED entry.
    if (state_d != ST_LOCKED) begin
      stdy_d      = '0;
      stdy_flag_d = 1'b0;
      stdy_hold_d = 1'b0;
      chan_d      = '0;
      div_d       = '0;
`ifdef CC_PLL_LOSS_DETECT_EN
      loss_d      = '0;
`endif
    end

    for (int i = 0; i < int'(NUM_OUT); i++) begin
      en_d[i] = (state_d == ST_LOCKED) && (chan_d[i] == div_last[i]);
    end
  end

  // State and output registers
  always_ff @(posedge CLK_REF or negedge USR_RSTN) begin
    if (!USR_RSTN) begin
      state_q     <= ST_IDLE;
      acq_q       <= '0;
      stdy_q      <= '0;
      stdy_flag_q <= 1'b0;
      stdy_hold_q <= 1'b0;
      chan_q      <= '0;
      div_q       <= '0;
      en_q        <= '0;
`ifdef CC_PLL_LOSS_DETECT_EN
      loss_q      <= '0;
      lost_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acq_q       <= acq_d;
      stdy_q      <= stdy_d;
      stdy_flag_q <= stdy_flag_d;
      stdy_hold_q <= stdy_hold_d;
      chan_q      <= chan_d;
      div_q       <= div_d;
      en_q        <= en_d;
`ifdef CC_PLL_LOSS_DETECT_EN
      loss_q      <= loss_d;
      lost_q      <= lost_d;
`endif
    end
  end

  assign bus.USR_PLL_LOCKED      = (state_q == ST_LOCKED);
  assign bus.USR_PLL_LOCKED_STDY = stdy_flag_q;
  assign bus.CLK_EN              = en_q;
  assign bus.CLK_DIV             = div_q;
`ifdef CC_PLL_LOSS_DETECT_EN
  assign bus.LOCK_LOST           = lost_q;
`endif

endmodule

// File: tb/tb_cc_pll_lock_model.sv
// tb_cc_pll_lock_model: directed, scoreboard-checked bench for cc_pll_lock_model
// with LOCK_CYCLES=8, STDY_CYCLES=4, DIV_RATIO={3,1}. Stimulus pushes the
// expected output vector for a given clock edge; the monitor samples on the
// falling edge and compares against the queue head for that edge.
module tb_cc_pll_lock_model;

  localparam int unsigned     NUM_OUT   = 2;
  localparam int unsigned     DIV_WIDTH = 8;
  localparam logic [15:0]     DIV_RATIO = {8'd3, 8'd1};
  localparam int unsigned     LOCK_CYC  = 8;
  localparam int unsigned     STDY_CYC  = 4;
  localparam int unsigned     LOSS_CYC  = 4;

  // Observed vector: {locked, stdy, CLK_EN[1:0], CLK_DIV[1:0], lock_lost}
  localparam logic [6:0] ALL        = 7'b1111111;
  localparam logic [6:0] LK_ST      = 7'b1100000;
  localparam logic [6:0] LK_ST_LOST = 7'b1100001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cc_pll_lock_model_if #(.NUM_OUT(NUM_OUT)) bus ();

  cc_pll_lock_model #(
    .NUM_OUT    (NUM_OUT),
    .DIV_WIDTH  (DIV_WIDTH),
    .DIV_RATIO  (DIV_RATIO),
    .LOCK_CYCLES(LOCK_CYC),
    .STDY_CYCLES(STDY_CYC),
    .LOSS_CYCLES(LOSS_CYC)
  ) dut (
    .CLK_REF (clk),
    .USR_RSTN(rst_n),
    .bus     (bus)
  );

  logic lost_obs;
`ifdef CC_PLL_LOSS_DETECT_EN
  assign lost_obs = bus.LOCK_LOST;
`else
  assign lost_obs = 1'b0;
`endif

  logic [6:0] obs;
  assign obs = {bus.USR_PLL_LOCKED, bus.USR_PLL_LOCKED_STDY, bus.CLK_EN, bus.CLK_DIV, lost_obs};

  typedef struct {
    int         cyc;
    logic [6:0] val;
    logic [6:0] mask;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k;
  int   f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [6:0] v, input logic [6:0] m, input string nm);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.mask = m;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Expected outputs j edges after the edge that first samples PLL_EN=1
  function automatic logic [6:0] lock_exp(input int j);
    int   m;
    logic lk, st, e0, e1, d0, d1;
    m  = j - 7;
    lk = (j >= 8);
    st = (j >= 12);
    e0 = (m >= 1);
    e1 = (m >= 1) && (m % 3 == 0);
    d0 = (m >= 1) && (m % 2 == 0);
    d1 = (m >= 1) && (((m - 1) / 3) % 2 == 1);
    return {lk, st, e1, e0, d1, d0, 1'b0};
  endfunction

  task automatic push_window(input int kk, input int j_lo, input int j_hi, input string nm);
    for (int j = j_lo; j <= j_hi; j++) expect_at(kk + j, lock_exp(j), ALL, nm);
  endtask

  task automatic run_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at the current edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for edge %0d not sampled (now edge %0d)", mon_e.name, mon_e.cyc, cyc);
      end else if (((obs ^ mon_e.val) & mon_e.mask) !== 7'd0) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %b required %b (mask %b)", mon_e.name, cyc, obs, mon_e.val, mon_e.mask);
      end
    end
  end

  initial begin
    rst_n                   = 1'b0;
    bus.PLL_EN              = 1'b0;
    bus.USR_LOCKED_STDY_RST = 1'b0;
`ifdef CC_PLL_LOSS_DETECT_EN
    bus.REF_GOOD            = 1'b1;
`endif

    // Reset state, then idle with enable low
    expect_at(1, 7'd0, ALL, "reset");
    expect_at(2, 7'd0, ALL, "reset");
    run_to(2);
    rst_n = 1'b1;
    expect_at(3, 7'd0, ALL, "idle");
    expect_at(4, 7'd0, ALL, "idle");
    run_to(4);

    // Acquire, lock, steady flag, channel pattern
    bus.PLL_EN = 1'b1;
    k = cyc + 1;
    push_window(k, 0, 22, "lock_a");
    run_to(k + 22);

    // One-cycle steady clear: flag low for STDY_CYCLES+1 cycles
    bus.USR_LOCKED_STDY_RST = 1'b1;
    k = cyc + 1;
    for (int d = 0; d <= 6; d++)
      expect_at(k + d, (d >= 5) ? 7'b1100000 : 7'b1000000, LK_ST, "stdy_clr");
    run_to(k);
    bus.USR_LOCKED_STDY_RST = 1'b0;
    run_to(k + 6);

    // Enable drop, relock, drop at LOCKED cycle 5, re-raise 2 cycles later
    bus.PLL_EN = 1'b0;
    expect_at(cyc + 1, 7'd0, ALL, "drop");
    run_to(cyc + 1);
    bus.PLL_EN = 1'b1;
    k = cyc + 1;
    push_window(k, 0, 12, "relock");
    run_to(k + 12);
    bus.PLL_EN = 1'b0;
    expect_at(k + 13, 7'd0, ALL, "drop_l5");
    expect_at(k + 14, 7'd0, ALL, "drop_l5");
    run_to(k + 14);
    bus.PLL_EN = 1'b1;
    k = cyc + 1;
    push_window(k, 0, 14, "realign");
    run_to(k + 14);

    // Reset mid-ACQUIRE then full acquire
    bus.PLL_EN = 1'b0;
    expect_at(cyc + 1, 7'd0, ALL, "drop2");
    run_to(cyc + 1);
    bus.PLL_EN = 1'b1;
    k = cyc + 1;
    push_window(k, 0, 3, "acq_pre_rst");
    run_to(k + 3);
    #2 rst_n = 1'b0;
    expect_at(k + 4, 7'd0, ALL, "rst_acq");
    expect_at(k + 5, 7'd0, ALL, "rst_acq");
    run_to(k + 5);
    rst_n = 1'b1;
    k = cyc + 1;
    push_window(k, 0, 14, "acq_after_rst");
    run_to(k + 14);

    // Reset mid-LOCKED: outputs clear before the next clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_at(cyc, 7'd0, ALL, "rst_async");
    expect_at(cyc + 1, 7'd0, ALL, "rst_hold");
    run_to(cyc + 1);
    rst_n = 1'b1;
    k = cyc + 1;
    push_window(k, 0, 12, "relock_rst");
    run_to(k + 12);

`ifdef CC_PLL_LOSS_DETECT_EN
    // REF_GOOD low 3 edges holds lock; 4 edges drops to ACQUIRE
    bus.REF_GOOD = 1'b0;
    k = cyc + 1;
    for (int d = 0; d <= 3; d++) expect_at(k + d, 7'b1100000, LK_ST_LOST, "ref_low3");
    run_to(k + 2);
    bus.REF_GOOD = 1'b1;
    run_to(k + 3);
    bus.REF_GOOD = 1'b0;
    f = cyc + 1;
    for (int d = 0; d <= 2; d++) expect_at(f + d, 7'b1100000, LK_ST_LOST, "ref_low4_hold");
    for (int d = 3; d <= 10; d++) expect_at(f + d, 7'b0000001, LK_ST_LOST, "lock_lost");
    expect_at(f + 11, 7'b1000001, LK_ST_LOST, "relock_loss");
    run_to(f + 3);
    bus.REF_GOOD = 1'b1;
    run_to(f + 11);
    bus.PLL_EN = 1'b0;
    expect_at(cyc + 1, 7'd0, ALL, "lost_clr");
    run_to(cyc + 1);
`endif

    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
